sequencer_multi: RTL and testbench

Multi-channel, parametrised successor to the single-output sequencer. It fetches step words from an external memory port using an r_en/r_rdy handshake and buffers one full step in a shadow register. On each step tick it presents all CHANNELS words at once on the sequence output. It adds programmable length, loop/one-shot mode, underrun detection and an internal tick prescaler. It sits between the pattern memory and the LED/IO drivers.

---
 rtl/sequencer_multi.sv | 180 ++++++++++++++++++
 tb/tb_sequencer_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequencer_multi.sv
// sequencer_multi: multi-channel step sequencer.
// Fetches CHANNELS words per step from a pattern memory over an r_en/r_rdy
// handshake into a shadow buffer, then presents the whole step at once on each
// step tick. Supports programmable length, loop/one-shot and sticky underrun.
// The step output is named seq_out because `sequence` is a reserved word.
// Build option SEQUENCER_EXT_TICK_EN: step tick comes from an external slow
// clock (step_tick, synchronised and edge-detected) instead of the prescaler.
module sequencer_multi #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned MEMORY_QTY   = 16,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned TICK_DIV     = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            run,
  input  logic                            loop,
  input  logic [ADDRESS_SIZE-1:0]         seq_len,
  input  logic [WORD_SIZE-1:0]            r_data,
  input  logic                            r_rdy,
`ifdef SEQUENCER_EXT_TICK_EN
  input  logic                            step_tick,
`endif
  output logic [ADDRESS_SIZE-1:0]         r_addr,
  output logic                            r_en,
  output logic [CHANNELS*WORD_SIZE-1:0]   seq_out,
  output logic                            busy,
  output logic                            done,
  output logic                            underrun
);

  localparam int unsigned Steps = MEMORY_QTY / CHANNELS;
  localparam int unsigned ChW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StGap, StReady, StDone} state_e;

  state_e                          state_q, state_d;
  logic [ADDRESS_SIZE-1:0]         step_q, step_d;
  logic [ADDRESS_SIZE-1:0]         last_q, last_d;   // index of final step in a pass
  logic [ChW-1:0]                  ch_q, ch_d;
  logic                            loop_q, loop_d;
  logic [CHANNELS*WORD_SIZE-1:0]   shadow_q, shadow_d;
  logic [CHANNELS*WORD_SIZE-1:0]   seq_q, seq_d;
  logic                            underrun_q, underrun_d;
  logic                            tick;
  logic                            start;

  assign start = (state_q == StIdle) && run;

`ifdef SEQUENCER_EXT_TICK_EN
  // Two-flop synchroniser plus one delayed copy for rising-edge detection
  logic [2:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], step_tick};
  end

  assign tick = busy && sync_q[1] && !sync_q[2];
`else
  localparam int unsigned PreW = $clog2(TICK_DIV);
  logic [PreW-1:0] presc_q, presc_d;

  assign tick = busy && (presc_q == PreW'(TICK_DIV - 1));

  // Prescaler restarts on leaving IDLE and only advances while busy
  always_comb begin
    presc_d = presc_q;
    if (start)     presc_d = '0;
    else if (busy) presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Prescaler register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`endif

  // Next-state, step/channel bookkeeping, shadow capture and presentation
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    last_d     = last_q;
    ch_d       = ch_q;
    loop_d     = loop_q;
    shadow_d   = shadow_q;
    seq_d      = seq_q;
    underrun_d = underrun_q;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StFetch;
          loop_d     = loop;
          underrun_d = 1'b0;
          step_d     = '0;
          ch_d       = '0;
          if ((seq_len == '0) || (32'(seq_len) > Steps)) last_d = ADDRESS_SIZE'(Steps - 1);
          else                                           last_d = seq_len - 1'b1;
        end
      end
      StFetch: begin
        // r_en is held until the handshake completes, even when stopping
        if (r_rdy) begin
          shadow_d[ch_q*WORD_SIZE +: WORD_SIZE] = r_data;
          state_d = run ? StGap : StIdle;
        end
      end
      StGap: begin
        if (!run) begin
          state_d = StIdle;
        end else if (32'(ch_q) < CHANNELS - 1) begin
          ch_d    = ch_q + 1'b1;
          state_d = StFetch;
        end else begin
          ch_d    = '0;
          state_d = StReady;
        end
      end
      StReady: begin
        if (!run) begin
          state_d = StIdle;
        end else if (tick) begin
          seq_d = shadow_q;
          if (step_q == last_q) begin
            if (loop_q) begin
              step_d  = '0;
              state_d = StFetch;
            end else begin
              state_d = StDone;
            end
          end else begin
            step_d  = step_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        if (!run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A tick before the step is fully buffered is an underrun; fetch carries on
    if (tick && ((state_q == StFetch) || (state_q == StGap))) underrun_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      step_q     <= '0;
      last_q     <= '0;
      ch_q       <= '0;
      loop_q     <= 1'b0;
      shadow_q   <= '0;
      seq_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      last_q     <= last_d;
      ch_q       <= ch_d;
      loop_q     <= loop_d;
      shadow_q   <= shadow_d;
      seq_q      <= seq_d;
      underrun_q <= underrun_d;
    end
  end

  assign busy     = (state_q == StFetch) || (state_q == StGap) || (state_q == StReady);
  assign done     = (state_q == StDone);
  assign r_en     = (state_q == StFetch);
  assign r_addr   = ADDRESS_SIZE'(step_q * ADDRESS_SIZE'(CHANNELS)) + ADDRESS_SIZE'(ch_q);
  assign seq_out  = seq_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_sequencer_multi.sv
// Testbench for sequencer_multi: memory responder with configurable r_rdy
// latency, scoreboard of expected step words, directed and random runs.
module tb_sequencer_multi;

  localparam int W     = 8;
  localparam int A     = 4;
  localparam int Q     = 16;
  localparam int C     = 2;
  localparam int TD    = 8;
  localparam int STEPS = Q / C;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           run = 1'b0;
  logic           loop = 1'b0;
  logic [A-1:0]   seq_len = '0;
  logic [W-1:0]   r_data = '0;
  logic           r_rdy = 1'b0;
  logic [A-1:0]   r_addr;
  logic           r_en;
  logic [C*W-1:0] seq_out;
  logic           busy, done, underrun;

`ifdef SEQUENCER_EXT_TICK_EN
  logic step_tick = 1'b0;
  always #40 step_tick = ~step_tick;
`endif

  sequencer_multi #(
    .WORD_SIZE(W), .ADDRESS_SIZE(A), .MEMORY_QTY(Q), .CHANNELS(C), .TICK_DIV(TD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .loop     (loop),
    .seq_len  (seq_len),
    .r_data   (r_data),
    .r_rdy    (r_rdy),
`ifdef SEQUENCER_EXT_TICK_EN
    .step_tick(step_tick),
`endif
    .r_addr   (r_addr),
    .r_en     (r_en),
    .seq_out  (seq_out),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clock = ~clock;

  logic [W-1:0]   mem [Q];
  logic [C*W-1:0] sb_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;
  int rdy_delay = 1;
  int wait_cnt  = 0;
  bit rand_delay = 1'b0;
  int exp_addr  = 0;
  int run_steps = STEPS;
  int low_cnt   = 0;
  bit prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [C*W-1:0] step_word(input int s);
    logic [C*W-1:0] w;
    for (int c = 0; c < C; c++) w[c*W +: W] = mem[s*C + c];
    return w;
  endfunction

  function automatic int eff_len(input int len);
    return ((len == 0) || (len > STEPS)) ? STEPS : len;
  endfunction

  // Memory responder: answers r_en after rdy_delay cycles, checks address order
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdy    = 1'b0;
      wait_cnt = 0;
    end else begin
      #1;
      if (r_rdy) begin
        r_rdy    = 1'b0;
        wait_cnt = 0;
        exp_addr = (exp_addr + 1) % (run_steps * C);
        if (rand_delay) rdy_delay = $urandom_range(1, 4);
      end else if (r_en) begin
        check_eq("r_addr", 32'(r_addr), 32'(exp_addr));
        if (wait_cnt >= rdy_delay) begin
          r_rdy  = 1'b1;
          r_data = mem[exp_addr];
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Presentation monitor: a step is presented when r_en rises after GAP+READY
  // (>=2 low busy cycles) or when a one-shot pass enters DONE
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      low_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if ((r_en && low_cnt >= 2) || (done && !prev_done)) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          check_eq("seq_out", 32'(seq_out), 32'(sb_q.pop_front()));
          pops++;
        end
      end
      if (busy && !r_en) low_cnt++;
      else               low_cnt = 0;
      prev_done = done;
    end
  end

  task automatic step_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic start_run(input bit lp, input int len, input int n_push);
    loop      = lp;
    seq_len   = A'(len);
    run_steps = eff_len(len);
    exp_addr  = 0;
    pops      = 0;
    sb_q.delete();
    for (int i = 0; i < n_push; i++) sb_q.push_back(step_word(i % run_steps));
    run = 1'b1;
  endtask

  task automatic stop_run(input string tag);
    run = 1'b0;
    for (int k = 0; k < 20 && busy; k++) step_cycle();
    check_eq(tag, 32'(busy), 32'd0);
    sb_q.delete();
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int k = 0; k < budget && pops < n; k++) step_cycle();
  endtask

  logic [C*W-1:0] seq_before;
  bit             hs;

  initial begin
    for (int a = 0; a < Q; a++) mem[a] = W'(a + 1);

    // Reset values
    #1 reset = 1'b0;
    #1;
    check_eq("rst_r_en", 32'(r_en), 32'd0);
    check_eq("rst_seq", 32'(seq_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    check_eq("rst_r_addr", 32'(r_addr), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    step_cycle();

    // Underrun: slow memory, first tick arrives before the step is buffered
    rdy_delay = 10;
    start_run(1'b1, 0, 2);
    for (int k = 0; k < 40 && !underrun; k++) step_cycle();
    check_eq("ur_flag", 32'(underrun), 32'd1);
    check_eq("ur_hold", 32'(seq_out), 32'd0);
    wait_pops(1, 60);
    check_eq("ur_pops", 32'(pops), 32'd1);

    // Stop mid-handshake: DUT is now fetching step 1; r_rdy held off 3 cycles
    seq_before = seq_out;
    rdy_delay  = 3;
    run        = 1'b0;
    hs         = 1'b0;
    for (int k = 0; k < 10 && !hs; k++) begin
      step_cycle();
      check_eq("stop_ren_hold", 32'(r_en), 32'd1);
      if (r_rdy) hs = 1'b1;
    end
    check_eq("stop_hs", 32'(hs), 32'd1);
    step_cycle();
    check_eq("stop_idle_ren", 32'(r_en), 32'd0);
    check_eq("stop_idle_busy", 32'(busy), 32'd0);
    check_eq("stop_seq_hold", 32'(seq_out), 32'(seq_before));
    sb_q.delete();
    step_cycle();

    // Basic loop: eight steps then wrap, no underrun
    rdy_delay = 1;
    start_run(1'b1, 0, 10);
    wait_pops(10, 200);
    check_eq("basic_pops", 32'(pops), 32'd10);
    check_eq("basic_underrun", 32'(underrun), 32'd0);
    check_eq("basic_wrap_seq", 32'(seq_out), 32'h0403);
    stop_run("basic_stop");
    step_cycle();

    // One-shot, three steps
    start_run(1'b0, 3, 3);
    for (int k = 0; k < 100 && !done; k++) step_cycle();
    check_eq("os_done", 32'(done), 32'd1);
    check_eq("os_busy", 32'(busy), 32'd0);
    check_eq("os_pops", 32'(pops), 32'd3);
    check_eq("os_seq", 32'(seq_out), 32'h0605);
    for (int k = 0; k < 5; k++) begin
      step_cycle();
      check_eq("os_hold", {30'd0, r_en, done}, 32'd1);
    end
    run = 1'b0;
    step_cycle();
    check_eq("os_done_clr", 32'(done), 32'd0);
    sb_q.delete();
    step_cycle();

    // Randomised data, length and memory latency
    for (int a = 0; a < Q; a++) mem[a] = W'($urandom);
    rand_delay = 1'b1;
    rdy_delay  = $urandom_range(1, 4);
    start_run(1'b1, int'($urandom_range(0, 15)), 400);
    repeat (1000) step_cycle();
    check_eq("rand_progress", 32'(pops >= 20), 32'd1);
    stop_run("rand_stop");
    rand_delay = 1'b0;
    for (int a = 0; a < Q; a++) mem[a] = W'(a + 1);
    step_cycle();

    // Async reset mid-FETCH with underrun set and a step on the output
    rdy_delay = 10;
    start_run(1'b1, 0, 4);
    wait_pops(1, 60);
    check_eq("mid_pre_ren", 32'(r_en), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("mid_r_en", 32'(r_en), 32'd0);
    check_eq("mid_seq", 32'(seq_out), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_done", 32'(done), 32'd0);
    check_eq("mid_underrun", 32'(underrun), 32'd0);
    run = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    step_cycle();
    step_cycle();
    check_eq("post_rst_idle", {30'd0, busy, r_en}, 32'd0);

    // Fresh start after reset fetches from address 0 again
    rdy_delay = 1;
    start_run(1'b1, 0, 2);
    wait_pops(2, 60);
    check_eq("post_rst_pops", 32'(pops), 32'd2);
    stop_run("post_rst_stop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
